fwd_operand_stage: RTL and testbench
====================================

Name: fwd_operand_stage

Overview:
- Parametrised D->E operand pipeline stage with built-in forwarding and load-use hazard detection.
- Latches NSRC register-file operands at the D/E boundary, applies a W->D write-through bypass on capture, and forwards from M (ALU result) or W (writeback result) in E.
- Raises stall_D on load-use hazards and on downstream hold.
- Sits between the register file / decode and the ALU input selection in the 5-stage core.

Parameters:
- DATA_W, 32, operand width in bits.
- AW, 5, register address width; address 0 is hardwired zero and never matches.
- NSRC, 2, number of source operands per instruction.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- hold_E  in  1  downstream freeze; E registers keep value
- valid_D  in  1  D-stage instruction valid
- use_D  in  NSRC  per-source "operand actually read" mask
- src_addr_D  in  NSRC*AW  source register numbers, source i at [i*AW +: AW]
- src_data_D  in  NSRC*DATA_W  register-file read data
- wr_en_E, is_load_E  in  1 each  E-stage instruction writes a register / is a load
- wr_addr_E  in  AW  E-stage destination
- wr_en_M  in  1  M-stage write enable
- wr_addr_M  in  AW  M-stage destination
- alu_o_M  in  DATA_W  M-stage ALU result
- wr_en_W  in  1  W-stage write enable
- wr_addr_W  in  AW  W-stage destination
- result_W  in  DATA_W  W-stage writeback value
- stall_D  out  1  hold F/D, insert bubble into E
- valid_E  out  1  E-stage operands valid
- opnd_E  out  NSRC*DATA_W  forwarded operands to ALU
- fwd_sel_E  out  NSRC*2  per-source select: 00 reg, 01 W, 10 M

Behaviour:
- Reset (reset==0 at posedge): valid_E=0; addr_E and data_E cleared to 0. Outputs follow: opnd_E=0, fwd_sel_E=00. stall_D is forced 0 while reset is low. A reset mid-stall drops the stall the same cycle.
- Load-use hazard (combinational): luh=1 when valid_D && wr_en_E && is_load_E && some i satisfies use_D[i] && src_addr_D[i]==wr_addr_E && wr_addr_E!=0.
- stall_D = reset && (luh || hold_E).
- Priority at each posedge, reset deasserted:
  - hold_E=1: all E registers hold. This takes precedence over luh.
  - Else luh=1: bubble; valid_E<=0, addr_E<=0, data_E<=0.
  - Else capture: valid_E<=valid_D, addr_E[i]<=src_addr_D[i].
- W->D write-through on capture: data_E[i]<=result_W when wr_en_W && wr_addr_W==src_addr_D[i] && src_addr_D[i]!=0; otherwise data_E[i]<=src_data_D[i].
- E forwarding, per source, combinational from E registers and current M/W inputs:
  - valid_E=0 or addr_E[i]==0: sel 00.
  - Else wr_en_M && wr_addr_M==addr_E[i]: sel 10, opnd=alu_o_M. M has priority over W (newest producer).
  - Else wr_en_W && wr_addr_W==addr_E[i]: sel 01, opnd=result_W.
  - Else sel 00, opnd=data_E[i].
- Latency: one clock from D capture to opnd_E. Forwarding adds zero cycles. A load-use hazard costs exactly one bubble, after which the load is in W and forwards via sel 01.
- A load in M never forwards alu_o_M for a consumer in E; that case cannot arise given the luh stall.
- All sources are evaluated independently. Both sources may forward from different stages in the same cycle.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds outputs stall_cnt (16) and fwd_cnt (16).
  - stall_cnt increments on each cycle luh=1 && hold_E=0.
  - fwd_cnt increments by 1 on each cycle where valid_E=1 and any fwd_sel_E!=00.
  - Both counters saturate at 0xFFFF and clear on reset.
- When undefined, these ports and counters do not exist. Core behaviour is identical in both cases.

Test Plan:
- Reset low 2 cycles with valid_D=1 and luh conditions true -> stall_D=0, valid_E=0, opnd_E=0 and fwd_sel_E=0 throughout; after release, first capture appears next cycle.
- D reads r3=0x11 with M writing r3=0xAAAA and W writing r3=0xBBBB in E -> fwd_sel 10, opnd=0xAAAA; remove the M match -> sel 01, opnd=0xBBBB.
- E is a load to r5 and D uses r5 on source 1 -> stall_D=1 for one cycle, bubble (valid_E=0). Next cycle the consumer captures; with W writing r5=0x1234 -> opnd=0x1234, sel 01.
- Same case with use_D[1]=0, or wr_addr_E=0 -> no stall.
- D reads r7 (regfile 0x0) while W writes r7=0x55 -> data_E captures 0x55. With no M/W match in E, opnd=0x55, sel 00.
- hold_E=1 for 3 cycles mid-stream -> stall_D=1; E registers and opnd_E stable when M/W inputs are unchanged. Assert luh during the hold -> no bubble until the hold releases.
- FWD_STATS_EN: 70000 forced-forward cycles -> fwd_cnt=0xFFFF, no wrap.

Source files
------------

// File: rtl/fwd_operand_stage.sv
// D->E operand stage: latches source operands with W write-through, forwards from M/W in E, detects load-use.
// Optional FWD_STATS_EN macro adds saturating stall/forward counters.
`timescale 1ns/1ps
module fwd_operand_stage #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NSRC   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold_E,
  input  logic                     valid_D,
  input  logic [NSRC-1:0]          use_D,
  input  logic [NSRC*AW-1:0]       src_addr_D,
  input  logic [NSRC*DATA_W-1:0]   src_data_D,
  input  logic                     wr_en_E,
  input  logic                     is_load_E,
  input  logic [AW-1:0]            wr_addr_E,
  input  logic                     wr_en_M,
  input  logic [AW-1:0]            wr_addr_M,
  input  logic [DATA_W-1:0]        alu_o_M,
  input  logic                     wr_en_W,
  input  logic [AW-1:0]            wr_addr_W,
  input  logic [DATA_W-1:0]        result_W,
  output logic                     stall_D,
  output logic                     valid_E,
  output logic [NSRC*DATA_W-1:0]   opnd_E,
  output logic [NSRC*2-1:0]        fwd_sel_E
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              fwd_cnt
`endif
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_W   = 2'b01;
  localparam logic [1:0] SEL_M   = 2'b10;

  logic                   valid_q, valid_d;
  logic [NSRC*AW-1:0]     addr_q, addr_d;
  logic [NSRC*DATA_W-1:0] data_q, data_d;
  logic                   luh;

  // Register 0 is hardwired zero, so a write to it never matches a reader.
  function automatic logic addr_hit(input logic en, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    return en && (wa == ra) && (ra != {AW{1'b0}});
  endfunction

  // Load-use hazard: a D source needs the result of a load still in E.
  always_comb begin
    luh = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      luh = luh | (use_D[i] & addr_hit(wr_en_E, wr_addr_E, src_addr_D[i*AW +: AW]));
    end
    luh = luh & valid_D & is_load_E;
  end

  assign stall_D = reset && (luh || hold_E);

  // E register next-state: hold beats bubble beats capture.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (hold_E) begin
      valid_d = valid_q;
    end else if (luh) begin
      valid_d = 1'b0;
      addr_d  = {(NSRC*AW){1'b0}};
      data_d  = {(NSRC*DATA_W){1'b0}};
    end else begin
      valid_d = valid_D;
      addr_d  = src_addr_D;
      for (int i = 0; i < NSRC; i++) begin
        if (addr_hit(wr_en_W, wr_addr_W, src_addr_D[i*AW +: AW])) begin
          data_d[i*DATA_W +: DATA_W] = result_W;
        end else begin
          data_d[i*DATA_W +: DATA_W] = src_data_D[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // D/E boundary registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= {(NSRC*AW){1'b0}};
      data_q  <= {(NSRC*DATA_W){1'b0}};
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_E = valid_q;

  // E forwarding: M is the newest producer so it wins over W.
  always_comb begin
    opnd_E    = data_q;
    fwd_sel_E = {(NSRC*2){1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (!valid_q) begin
        fwd_sel_E[i*2 +: 2] = SEL_REG;
      end else if (addr_hit(wr_en_M, wr_addr_M, addr_q[i*AW +: AW])) begin
        fwd_sel_E[i*2 +: 2]        = SEL_M;
        opnd_E[i*DATA_W +: DATA_W] = alu_o_M;
      end else if (addr_hit(wr_en_W, wr_addr_W, addr_q[i*AW +: AW])) begin
        fwd_sel_E[i*2 +: 2]        = SEL_W;
        opnd_E[i*DATA_W +: DATA_W] = result_W;
      end else begin
        fwd_sel_E[i*2 +: 2] = SEL_REG;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (luh && !hold_E && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (valid_q && (fwd_sel_E != {(NSRC*2){1'b0}}) && (fwd_cnt_q != 16'hFFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 16'd1;
    end else begin
      fwd_cnt_d = fwd_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      fwd_cnt_q   <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed self-checking bench for fwd_operand_stage; define FWD_STATS_EN to also exercise the counters.
`timescale 1ns/1ps
module tb_fwd_operand_stage;
  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam int NSRC   = 2;

  logic clk = 1'b0;
  logic reset, hold_E, valid_D;
  logic [NSRC-1:0] use_D;
  logic [NSRC*AW-1:0] src_addr_D;
  logic [NSRC*DATA_W-1:0] src_data_D;
  logic wr_en_E, is_load_E, wr_en_M, wr_en_W;
  logic [AW-1:0] wr_addr_E, wr_addr_M, wr_addr_W;
  logic [DATA_W-1:0] alu_o_M, result_W;
  logic stall_D, valid_E;
  logic [NSRC*DATA_W-1:0] opnd_E;
  logic [NSRC*2-1:0] fwd_sel_E;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_operand_stage #(.DATA_W(DATA_W), .AW(AW), .NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .hold_E(hold_E), .valid_D(valid_D), .use_D(use_D),
    .src_addr_D(src_addr_D), .src_data_D(src_data_D),
    .wr_en_E(wr_en_E), .is_load_E(is_load_E), .wr_addr_E(wr_addr_E),
    .wr_en_M(wr_en_M), .wr_addr_M(wr_addr_M), .alu_o_M(alu_o_M),
    .wr_en_W(wr_en_W), .wr_addr_W(wr_addr_W), .result_W(result_W),
    .stall_D(stall_D), .valid_E(valid_E), .opnd_E(opnd_E), .fwd_sel_E(fwd_sel_E)
`ifdef FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  task automatic set_idle();
    reset = 1'b1; hold_E = 1'b0; valid_D = 1'b0; use_D = 2'b00;
    src_addr_D = '0; src_data_D = '0;
    wr_en_E = 1'b0; is_load_E = 1'b0; wr_addr_E = 5'd0;
    wr_en_M = 1'b0; wr_addr_M = 5'd0; alu_o_M = 32'h0;
    wr_en_W = 1'b0; wr_addr_W = 5'd0; result_W = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0; valid_D = 1'b1; use_D = 2'b11; src_addr_D = {5'd5, 5'd5};
    src_data_D = {32'h77, 32'h66}; wr_en_E = 1'b1; is_load_E = 1'b1; wr_addr_E = 5'd5;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (stall_D !== 1'b0) begin failures++; $display("FAIL rst_stall got=%h exp=%h", stall_D, 1'b0); end
      checks++; if (valid_E !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=%h", valid_E, 1'b0); end
      checks++; if (opnd_E !== 64'h0) begin failures++; $display("FAIL rst_opnd got=%h exp=%h", opnd_E, 64'h0); end
      checks++; if (fwd_sel_E !== 4'b0000) begin failures++; $display("FAIL rst_sel got=%b exp=%b", fwd_sel_E, 4'b0000); end
    end
    reset = 1'b1; wr_en_E = 1'b0; is_load_E = 1'b0;
    src_addr_D = {5'd2, 5'd1}; src_data_D = {32'h22, 32'h11};
    #1;
    checks++; if (stall_D !== 1'b0) begin failures++; $display("FAIL rel_stall got=%h exp=%h", stall_D, 1'b0); end
    tick();
    checks++; if (valid_E !== 1'b1) begin failures++; $display("FAIL rel_valid got=%h exp=%h", valid_E, 1'b1); end
    checks++; if (opnd_E !== {32'h22, 32'h11}) begin failures++; $display("FAIL rel_opnd got=%h exp=%h", opnd_E, {32'h22, 32'h11}); end
  endtask

  task automatic test_fwd_priority();
    set_idle();
    valid_D = 1'b1; use_D = 2'b01; src_addr_D = {5'd0, 5'd3}; src_data_D = {32'h0, 32'h11};
    tick();
    valid_D = 1'b0;
    wr_en_M = 1'b1; wr_addr_M = 5'd3; alu_o_M = 32'hAAAA;
    wr_en_W = 1'b1; wr_addr_W = 5'd3; result_W = 32'hBBBB;
    #1;
    checks++; if (fwd_sel_E !== 4'b0010) begin failures++; $display("FAIL prio_m_sel got=%b exp=%b", fwd_sel_E, 4'b0010); end
    checks++; if (opnd_E !== {32'h0, 32'hAAAA}) begin failures++; $display("FAIL prio_m_opnd got=%h exp=%h", opnd_E, {32'h0, 32'hAAAA}); end
    wr_en_M = 1'b0;
    #1;
    checks++; if (fwd_sel_E !== 4'b0001) begin failures++; $display("FAIL prio_w_sel got=%b exp=%b", fwd_sel_E, 4'b0001); end
    checks++; if (opnd_E !== {32'h0, 32'hBBBB}) begin failures++; $display("FAIL prio_w_opnd got=%h exp=%h", opnd_E, {32'h0, 32'hBBBB}); end
    wr_en_W = 1'b0;
    #1;
    checks++; if (fwd_sel_E !== 4'b0000) begin failures++; $display("FAIL prio_reg_sel got=%b exp=%b", fwd_sel_E, 4'b0000); end
    checks++; if (opnd_E !== {32'h0, 32'h11}) begin failures++; $display("FAIL prio_reg_opnd got=%h exp=%h", opnd_E, {32'h0, 32'h11}); end
  endtask

  task automatic test_dual_fwd();
    set_idle();
    valid_D = 1'b1; use_D = 2'b11; src_addr_D = {5'd4, 5'd3}; src_data_D = {32'h44, 32'h33};
    tick();
    wr_en_M = 1'b1; wr_addr_M = 5'd3; alu_o_M = 32'hA3;
    wr_en_W = 1'b1; wr_addr_W = 5'd4; result_W = 32'hB4;
    #1;
    checks++; if (fwd_sel_E !== 4'b0110) begin failures++; $display("FAIL dual_sel got=%b exp=%b", fwd_sel_E, 4'b0110); end
    checks++; if (opnd_E !== {32'hB4, 32'hA3}) begin failures++; $display("FAIL dual_opnd got=%h exp=%h", opnd_E, {32'hB4, 32'hA3}); end
  endtask

  task automatic test_load_use();
    set_idle();
    valid_D = 1'b1; use_D = 2'b10; src_addr_D = {5'd5, 5'd1}; src_data_D = {32'hDEAD, 32'h10};
    wr_en_E = 1'b1; is_load_E = 1'b1; wr_addr_E = 5'd5;
    #1;
    checks++; if (stall_D !== 1'b1) begin failures++; $display("FAIL lu_stall got=%h exp=%h", stall_D, 1'b1); end
    tick();
    checks++; if (valid_E !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%h exp=%h", valid_E, 1'b0); end
    checks++; if (opnd_E !== 64'h0) begin failures++; $display("FAIL lu_bub_opnd got=%h exp=%h", opnd_E, 64'h0); end
    wr_en_E = 1'b0; is_load_E = 1'b0;
    wr_en_W = 1'b1; wr_addr_W = 5'd5; result_W = 32'h1234;
    #1;
    checks++; if (stall_D !== 1'b0) begin failures++; $display("FAIL lu_release got=%h exp=%h", stall_D, 1'b0); end
    tick();
    checks++; if (valid_E !== 1'b1) begin failures++; $display("FAIL lu_valid got=%h exp=%h", valid_E, 1'b1); end
    checks++; if (fwd_sel_E !== 4'b0100) begin failures++; $display("FAIL lu_sel got=%b exp=%b", fwd_sel_E, 4'b0100); end
    checks++; if (opnd_E !== {32'h1234, 32'h10}) begin failures++; $display("FAIL lu_opnd got=%h exp=%h", opnd_E, {32'h1234, 32'h10}); end
  endtask

  task automatic test_no_stall();
    set_idle();
    valid_D = 1'b1; use_D = 2'b01; src_addr_D = {5'd5, 5'd1};
    wr_en_E = 1'b1; is_load_E = 1'b1; wr_addr_E = 5'd5;
    #1;
    checks++; if (stall_D !== 1'b0) begin failures++; $display("FAIL ns_unused got=%h exp=%h", stall_D, 1'b0); end
    use_D = 2'b10;
    #1;
    checks++; if (stall_D !== 1'b1) begin failures++; $display("FAIL ns_used got=%h exp=%h", stall_D, 1'b1); end
    wr_addr_E = 5'd0; src_addr_D = {5'd0, 5'd1};
    #1;
    checks++; if (stall_D !== 1'b0) begin failures++; $display("FAIL ns_r0 got=%h exp=%h", stall_D, 1'b0); end
    wr_addr_E = 5'd5; src_addr_D = {5'd5, 5'd1}; is_load_E = 1'b0;
    #1;
    checks++; if (stall_D !== 1'b0) begin failures++; $display("FAIL ns_noload got=%h exp=%h", stall_D, 1'b0); end
    set_idle();
  endtask

  task automatic test_write_through();
    set_idle();
    valid_D = 1'b1; use_D = 2'b01; src_addr_D = {5'd0, 5'd7}; src_data_D = 64'h0;
    wr_en_W = 1'b1; wr_addr_W = 5'd7; result_W = 32'h55;
    tick();
    wr_en_W = 1'b0; valid_D = 1'b0;
    #1;
    checks++; if (fwd_sel_E !== 4'b0000) begin failures++; $display("FAIL wt_sel got=%b exp=%b", fwd_sel_E, 4'b0000); end
    checks++; if (opnd_E !== {32'h0, 32'h55}) begin failures++; $display("FAIL wt_opnd got=%h exp=%h", opnd_E, {32'h0, 32'h55}); end
  endtask

  task automatic test_hold();
    set_idle();
    valid_D = 1'b1; use_D = 2'b11; src_addr_D = {5'd9, 5'd8}; src_data_D = {32'h99, 32'h88};
    tick();
    hold_E = 1'b1; src_addr_D = {5'd10, 5'd11}; src_data_D = {32'hAA, 32'hBB};
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        wr_en_E = 1'b1; is_load_E = 1'b1; wr_addr_E = 5'd10;
      end
      #1;
      checks++; if (stall_D !== 1'b1) begin failures++; $display("FAIL hold_stall got=%h exp=%h", stall_D, 1'b1); end
      tick();
      checks++; if (valid_E !== 1'b1) begin failures++; $display("FAIL hold_valid got=%h exp=%h", valid_E, 1'b1); end
      checks++; if (opnd_E !== {32'h99, 32'h88}) begin failures++; $display("FAIL hold_opnd got=%h exp=%h", opnd_E, {32'h99, 32'h88}); end
    end
    hold_E = 1'b0;
    #1;
    checks++; if (stall_D !== 1'b1) begin failures++; $display("FAIL hold_luh got=%h exp=%h", stall_D, 1'b1); end
    tick();
    checks++; if (valid_E !== 1'b0) begin failures++; $display("FAIL hold_bubble got=%h exp=%h", valid_E, 1'b0); end
    wr_en_E = 1'b0; is_load_E = 1'b0;
    tick();
    checks++; if (opnd_E !== {32'hAA, 32'hBB}) begin failures++; $display("FAIL hold_after got=%h exp=%h", opnd_E, {32'hAA, 32'hBB}); end
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    set_idle();
    valid_D = 1'b1; use_D = 2'b01; src_addr_D = {5'd0, 5'd3};
    tick();
    hold_E = 1'b1; wr_en_M = 1'b1; wr_addr_M = 5'd3;
    #1;
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, 16'd2); end
    repeat (70000) tick();
    checks++; if (fwd_cnt !== 16'hFFFF) begin failures++; $display("FAIL fwd_cnt_sat got=%h exp=%h", fwd_cnt, 16'hFFFF); end
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL stall_cnt_hold got=%0d exp=%0d", stall_cnt, 16'd2); end
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_priority();
    test_dual_fwd();
    test_load_use();
    test_no_stall();
    test_write_through();
    test_hold();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
